// File: rtl/ula_pkg.sv
// Shared types for the pipelined ULA.
// Opcodes, stage bundle and shift-width helper.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_RSVD = 3'd7
  } ula_op_e;

  // Widest result a stage can carry; designs use the low 2*DATA_WIDTH bits.
  localparam int unsigned ULA_RES_MAX = 64;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [ULA_RES_MAX-1:0] result;
  } ula_stage_t;

  function automatic int unsigned shamt_w(input int unsigned dw);
    return $clog2(2 * dw);
  endfunction

endpackage

// File: rtl/ula_if.sv
// Operand/result handshake bundle for the pipelined ULA.
// Master drives operands and ready_i; slave returns results.
interface ula_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SEL_WIDTH   = 3,
  parameter int PIPE_STAGES = 2
);

  logic                    valid_i;
  logic                    ready_o;
  logic [DATA_WIDTH-1:0]   data_i_1;
  logic [DATA_WIDTH-1:0]   data_i_2;
  logic [SEL_WIDTH-1:0]    sel_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [2*DATA_WIDTH-1:0] data_o;
  logic                    err_o;
  logic                    busy_o;

  if (DATA_WIDTH < 2 || 2 * DATA_WIDTH >= 64) begin : g_bad_dw
    $error("ula_if: DATA_WIDTH out of range");
  end
  if (SEL_WIDTH < 3) begin : g_bad_sw
    $error("ula_if: SEL_WIDTH must be >= 3");
  end
  if (PIPE_STAGES < 1) begin : g_bad_ps
    $error("ula_if: PIPE_STAGES must be >= 1");
  end

  modport master (
    output valid_i, data_i_1, data_i_2, sel_i, ready_i,
    input  ready_o, valid_o, data_o, err_o, busy_o
  );

  modport slave (
    input  valid_i, data_i_1, data_i_2, sel_i, ready_i,
    output ready_o, valid_o, data_o, err_o, busy_o
  );

endinterface

// File: rtl/ula_core.sv
// Combinational opcode decode and compute for the ULA.
// Reserved opcodes yield a zero result with err set.
module ula_core #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic [SEL_WIDTH-1:0]    sel_i,
  output logic [2*DATA_WIDTH-1:0] res_o,
  output logic                    err_o
);

  import ula_pkg::*;

  localparam int RW  = 2 * DATA_WIDTH;
  localparam int SHW = shamt_w(DATA_WIDTH);

  ula_op_e       op;
  logic [RW-1:0] a_x;
  logic [RW-1:0] b_x;

  assign a_x = RW'(a_i);
  assign b_x = RW'(b_i);

  always_comb begin
    op = OP_RSVD;
    if (sel_i < SEL_WIDTH'(7)) begin
      op = ula_op_e'(sel_i[2:0]);
    end
  end

  // SUB on zero-extended operands is already sign-extended to RW.
  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): res_o = a_x + b_x;
      (op == OP_SUB): res_o = a_x - b_x;
      (op == OP_MUL): res_o = a_x * b_x;
      (op == OP_AND): res_o = a_x & b_x;
      (op == OP_OR):  res_o = a_x | b_x;
      (op == OP_XOR): res_o = a_x ^ b_x;
      (op == OP_SHL): res_o = a_x << b_i[SHW-1:0];
      default:        err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ula_pipe.sv
// Pipelined ULA with valid/ready handshake and global stall.
// Stage 0 registers operands; later stages delay {valid, err, result}.
module ula_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int SEL_WIDTH   = 3,
  parameter int PIPE_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  ula_if.slave bus
);

  import ula_pkg::*;

  localparam int RW = 2 * DATA_WIDTH;

  logic                  adv;
  logic                  s0_vld_q, s0_vld_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [RW-1:0]         core_res;
  logic                  core_err;
  ula_stage_t            core_st;
  ula_stage_t            out_st;
  logic                  dly_busy;
  logic                  unused_hi;

  assign adv         = bus.ready_i || !out_st.valid;
  assign bus.ready_o = !rst_n || adv;

  always_comb begin
    s0_vld_d = s0_vld_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    if (adv) begin
      s0_vld_d = bus.valid_i;
      a_d      = bus.data_i_1;
      b_d      = bus.data_i_2;
      sel_d    = bus.sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
    end else begin
      s0_vld_q <= s0_vld_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
    end
  end

  ula_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_core (
    .a_i   (a_q),
    .b_i   (b_q),
    .sel_i (sel_q),
    .res_o (core_res),
    .err_o (core_err)
  );

  always_comb begin
    core_st        = '0;
    core_st.valid  = s0_vld_q;
    core_st.err    = core_err;
    core_st.result = ULA_RES_MAX'(core_res);
  end

  if (PIPE_STAGES == 1) begin : g_direct
    assign out_st   = core_st;
    assign dly_busy = 1'b0;
  end else begin : g_dly
    localparam int ND = PIPE_STAGES - 1;

    ula_stage_t dly_q [ND];
    ula_stage_t dly_d [ND];

    always_comb begin
      for (int i = 0; i < ND; i++) begin
        dly_d[i] = dly_q[i];
      end
      if (adv) begin
        dly_d[0] = core_st;
        for (int i = 1; i < ND; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < ND; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < ND; i++) begin
          dly_q[i] <= dly_d[i];
        end
      end
    end

    always_comb begin
      dly_busy = 1'b0;
      for (int i = 0; i < ND; i++) begin
        dly_busy = dly_busy | dly_q[i].valid;
      end
    end

    assign out_st = dly_q[ND-1];
  end

  assign bus.valid_o = out_st.valid;
  assign bus.err_o   = out_st.err;
  assign bus.data_o  = out_st.result[RW-1:0];
  assign bus.busy_o  = s0_vld_q | dly_busy;
  assign unused_hi   = ^out_st.result[ULA_RES_MAX-1:RW];

endmodule

// File: tb/tb_ula_pipe.sv
// Scoreboard bench for ula_pipe at depths 2 and 1 in lockstep.
// Directed vectors with hand-computed results.
module tb_ula_pipe;

  typedef struct {
    logic [15:0] r;
    logic        e;
    bit          lat;
    int          acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy_i;
  logic       vi2, vi1;
  logic [7:0] da, db;
  logic [2:0] dsel;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;

  exp_t sb0[$];
  exp_t sb1[$];
  bit          fresh [2];
  bit          pst   [2];
  logic [15:0] pdat  [2];
  logic        perr  [2];

  ula_if #(.DATA_WIDTH(8), .SEL_WIDTH(3), .PIPE_STAGES(2)) b2 ();
  ula_if #(.DATA_WIDTH(8), .SEL_WIDTH(3), .PIPE_STAGES(1)) b1 ();

  assign b2.valid_i  = vi2;
  assign b2.data_i_1 = da;
  assign b2.data_i_2 = db;
  assign b2.sel_i    = dsel;
  assign b2.ready_i  = rdy_i;
  assign b1.valid_i  = vi1;
  assign b1.data_i_1 = da;
  assign b1.data_i_2 = db;
  assign b1.sel_i    = dsel;
  assign b1.ready_i  = rdy_i;

  ula_pipe #(
    .DATA_WIDTH  (8),
    .SEL_WIDTH   (3),
    .PIPE_STAGES (2)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  ula_pipe #(
    .DATA_WIDTH  (8),
    .SEL_WIDTH   (3),
    .PIPE_STAGES (1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon_step(input int d, input logic vo, input logic ro,
                          input logic ri, input logic eo,
                          input logic [15:0] dout);
    exp_t  e;
    string t;
    int    qs;
    t = (d == 0) ? "ps2" : "ps1";
    if (!mon_en) begin
      fresh[d] = 1'b1;
      pst[d]   = 1'b0;
      return;
    end
    if (pst[d]) begin
      chk({t, " hold_valid"}, 32'(vo), 32'd1);
      chk({t, " hold_data"}, 32'(dout), 32'(pdat[d]));
      chk({t, " hold_err"}, 32'(eo), 32'(perr[d]));
    end
    if (vo && !ri) chk({t, " stall_ready_o"}, 32'(ro), 32'd0);
    if (ri) chk({t, " free_ready_o"}, 32'(ro), 32'd1);
    if (vo) begin
      qs = (d == 0) ? sb0.size() : sb1.size();
      if (qs == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s unexpected_out: got %0h want none", t, dout);
      end else begin
        e = (d == 0) ? sb0[0] : sb1[0];
        if (fresh[d] && e.lat)
          chk({t, " latency"}, 32'(cyc - e.acc), (d == 0) ? 32'd1 : 32'd0);
        fresh[d] = 1'b0;
        if (ri) begin
          if (d == 0) void'(sb0.pop_front());
          else        void'(sb1.pop_front());
          chk({t, " data_o"}, 32'(dout), 32'(e.r));
          chk({t, " err_o"}, 32'(eo), 32'(e.e));
          fresh[d] = 1'b1;
        end
      end
    end
    pst[d]  = vo && !ri;
    pdat[d] = dout;
    perr[d] = eo;
  endtask

  always @(negedge clk) begin
    mon_step(0, b2.valid_o, b2.ready_o, rdy_i, b2.err_o, b2.data_o);
    mon_step(1, b1.valid_o, b1.ready_o, rdy_i, b1.err_o, b1.data_o);
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] r,
                      input logic e, input bit lat);
    bit p0, p1, a0, a1;
    int n;
    da = a; db = b; dsel = op;
    vi2 = 1'b1; vi1 = 1'b1;
    p0 = 1'b1; p1 = 1'b1; n = 0;
    while ((p0 || p1) && n < 50) begin
      @(negedge clk);
      a0 = vi2 && b2.ready_o;
      a1 = vi1 && b1.ready_o;
      @(posedge clk); #1;
      if (a0) begin
        vi2 = 1'b0; p0 = 1'b0;
        sb0.push_back('{r: r, e: e, lat: lat, acc: cyc});
      end
      if (a1) begin
        vi1 = 1'b0; p1 = 1'b0;
        sb1.push_back('{r: r, e: e, lat: lat, acc: cyc});
      end
      n++;
    end
    if (p0 || p1) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: got ready_o=0 want accept op=%0d", op);
      vi2 = 1'b0; vi1 = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d/%0d pending want 0/0",
               sb0.size(), sb1.size());
    end
  endtask

  logic [2:0]  v_op [12] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4,
                             3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd3};
  logic [7:0]  v_a  [12] = '{8'hFF, 8'h01, 8'h02, 8'hFF, 8'hF0, 8'h0F,
                             8'hF0, 8'h81, 8'h81, 8'h01, 8'h12, 8'h12};
  logic [7:0]  v_b  [12] = '{8'h01, 8'h02, 8'h01, 8'hFF, 8'h3C, 8'hA0,
                             8'h3C, 8'h09, 8'h10, 8'h0F, 8'h34, 8'h34};
  logic [15:0] v_r  [12] = '{16'h0100, 16'hFFFF, 16'h0001, 16'hFE01,
                             16'h0030, 16'h00AF, 16'h00CC, 16'h0200,
                             16'h0081, 16'h8000, 16'h0000, 16'h0010};
  logic        v_e  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [7:0]  s_a  [8] = '{8'h10, 8'h20, 8'h80, 8'hFF,
                            8'h01, 8'h7F, 8'h55, 8'hC0};
  logic [7:0]  s_b  [8] = '{8'h01, 8'h02, 8'h80, 8'hFF,
                            8'h00, 8'h01, 8'hAA, 8'h41};
  logic [15:0] s_r  [8] = '{16'h0011, 16'h0022, 16'h0100, 16'h01FE,
                            16'h0001, 16'h0080, 16'h00FF, 16'h0101};

  initial begin
    rst_n = 1'b0; rdy_i = 1'b1;
    vi2 = 1'b0; vi1 = 1'b0;
    da = '0; db = '0; dsel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst valid_o ps2", 32'(b2.valid_o), 32'd0);
    chk("rst busy_o ps2", 32'(b2.busy_o), 32'd0);
    chk("rst data_o ps2", 32'(b2.data_o), 32'd0);
    chk("rst err_o ps2", 32'(b2.err_o), 32'd0);
    chk("rst ready_o ps2", 32'(b2.ready_o), 32'd1);
    chk("rst valid_o ps1", 32'(b1.valid_o), 32'd0);
    chk("rst data_o ps1", 32'(b1.data_o), 32'd0);
    chk("rst ready_o ps1", 32'(b1.ready_o), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(v_op[i], v_a[i], v_b[i], v_r[i], v_e[i], 1'b1);
      wait_idle();
    end
    send(v_op[10], v_a[10], v_b[10], v_r[10], v_e[10], 1'b1);
    send(v_op[11], v_a[11], v_b[11], v_r[11], v_e[11], 1'b0);
    wait_idle();

    fork
      begin
        for (int i = 0; i < 8; i++)
          send(3'd0, s_a[i], s_b[i], s_r[i], 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_i = 1'b1;
      end
    join
    wait_idle();

    mon_en = 1'b0;
    da = 8'h01; db = 8'h01; dsel = 3'd0;
    vi2 = 1'b1; vi1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vi2 = 1'b0; vi1 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush valid_o ps2", 32'(b2.valid_o), 32'd0);
    chk("flush busy_o ps2", 32'(b2.busy_o), 32'd0);
    chk("flush data_o ps2", 32'(b2.data_o), 32'd0);
    chk("flush valid_o ps1", 32'(b1.valid_o), 32'd0);
    chk("flush busy_o ps1", 32'(b1.busy_o), 32'd0);
    chk("flush data_o ps1", 32'(b1.data_o), 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle busy_o ps2", 32'(b2.busy_o), 32'd0);
    chk("idle busy_o ps1", 32'(b1.busy_o), 32'd0);

    send(3'd0, 8'h7F, 8'h80, 16'h00FF, 1'b0, 1'b1);
    wait_idle();
    chk("sb0 empty", 32'(sb0.size()), 32'd0);
    chk("sb1 empty", 32'(sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
